// File: rtl/game_pkg.sv
// game_pkg: definitions shared by the game's display and update logic.
//   - grid size defaults and coordinate/address widths
//   - coordinate-to-address packing {X, Y}, also used for player-location fields
//   - colour constants
//   - frame_scanner state encoding
package game_pkg;

  localparam int X_MAX_DEF = 160;
  localparam int Y_MAX_DEF = 120;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int ADDR_W    = X_W + Y_W;
  localparam int COL_W     = 3;

  localparam logic [COL_W-1:0] COL_EMPTY = 3'b000;

  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_SCAN  = 2'd1,
    SC_DRAIN = 2'd2,
    SC_DONE  = 2'd3
  } scan_state_t;

  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/scan_delay.sv
// scan_delay: RD_LAT-stage shift register carrying {valid, x, y} of issued
// RAM reads, so the coordinates arrive together with the read data.
//   i_clk    clock
//   i_rst_n  synchronous active-low clear (invalidates every stage)
//   i_vld    a read is issued this cycle
//   i_x/i_y  coordinates of the issued read
//   o_vld    read data for o_x/o_y is on the RAM output this cycle
//   o_any    at least one read is still in flight
module scan_delay
  import game_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_vld,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  output logic           o_vld,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_any
);

  logic [RD_LAT-1:0]          r_vld;
  logic [RD_LAT-1:0][X_W-1:0] r_x;
  logic [RD_LAT-1:0][Y_W-1:0] r_y;

  // Stage boundary: issue -> delay line (only the valid bits need clearing)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_x[0] <= i_x;
    r_y[0] <= i_y;
    for (int i = 1; i < RD_LAT; i++) begin
      r_x[i] <= r_x[i-1];
      r_y[i] <= r_y[i-1];
    end
  end

  assign o_vld = r_vld[RD_LAT-1];
  assign o_x   = r_x[RD_LAT-1];
  assign o_y   = r_y[RD_LAT-1];
  assign o_any = |r_vld;

endmodule

// File: rtl/frame_scanner.sv
// frame_scanner: on each game tick, reads every cell of the play grid from the
// shared grid RAM (only when granted) and emits one VGA plot per cell in
// raster order (X fastest).
//   CLOCK_50    clock
//   resetn      synchronous active-low reset
//   clonke      game-tick pulse requesting a frame
//   ram_grant   a read may be issued this cycle
//   rd_address  RAM address {x_cnt, y_cnt} while scanning, 0 otherwise
//   rd_q        RAM read data, RD_LAT cycles after the address
//   x/y/colour  registered plot coordinates and colour
//   plot        VGA write strobe
//   busy        a frame is in progress (scan, drain or done)
//   frame_done  one-cycle pulse after the last plot of a frame
module frame_scanner
  import game_pkg::*;
#(
  parameter int X_MAX  = X_MAX_DEF,
  parameter int Y_MAX  = Y_MAX_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              clonke,
  input  logic              ram_grant,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [COL_W-1:0]  rd_q,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [COL_W-1:0]  colour,
  output logic              plot,
  output logic              busy,
  output logic              frame_done
);

  scan_state_t    r_state, w_next;
  logic [X_W-1:0] r_x_cnt;
  logic [Y_W-1:0] r_y_cnt;
  logic           r_pending;

  logic           w_issue, w_x_wrap, w_last_cell;
  logic           w_dl_vld, w_dl_any;
  logic [X_W-1:0] w_dl_x;
  logic [Y_W-1:0] w_dl_y;

  assign w_issue     = (r_state == SC_SCAN) && ram_grant;
  assign w_x_wrap    = (r_x_cnt == X_W'(X_MAX - 1));
  assign w_last_cell = w_x_wrap && (r_y_cnt == Y_W'(Y_MAX - 1));

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) r_state <= SC_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b1;
    frame_done = 1'b0;
    rd_address = '0;
    case (r_state)
      SC_IDLE: begin
        busy = 1'b0;
        if (clonke || r_pending) w_next = SC_SCAN;
      end
      SC_SCAN: begin
        rd_address = xy_to_addr(r_x_cnt, r_y_cnt);
        if (w_issue && w_last_cell) w_next = SC_DRAIN;
      end
      // Leave only once the final read has reached the output registers.
      SC_DRAIN: if (!w_dl_any) w_next = SC_DONE;
      SC_DONE: begin
        frame_done = 1'b1;
        w_next     = SC_IDLE;
      end
      default: w_next = SC_IDLE;
    endcase
  end

  // Counters stop on the last cell, so they never leave the grid.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_x_cnt   <= '0;
      r_y_cnt   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (r_state == SC_IDLE) begin
        if (clonke || r_pending) begin
          r_x_cnt   <= '0;
          r_y_cnt   <= '0;
          r_pending <= 1'b0;
        end
      end else if (clonke) begin
        r_pending <= 1'b1;
      end
      if (w_issue && !w_last_cell) begin
        if (w_x_wrap) begin
          r_x_cnt <= '0;
          r_y_cnt <= r_y_cnt + 1'b1;
        end else begin
          r_x_cnt <= r_x_cnt + 1'b1;
        end
      end
    end
  end

  scan_delay #(.RD_LAT(RD_LAT)) u_delay (
    .i_clk   (CLOCK_50),
    .i_rst_n (resetn),
    .i_vld   (w_issue),
    .i_x     (r_x_cnt),
    .i_y     (r_y_cnt),
    .o_vld   (w_dl_vld),
    .o_x     (w_dl_x),
    .o_y     (w_dl_y),
    .o_any   (w_dl_any)
  );

  // Stage boundary: RAM data + delayed coordinates -> plot registers
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= COL_EMPTY;
      plot   <= 1'b0;
    end else begin
      plot <= w_dl_vld;
      if (w_dl_vld) begin
        x      <= w_dl_x;
        y      <= w_dl_y;
        colour <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_frame_scanner.sv
module tb_frame_scanner;

  localparam int NCELL = 160 * 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, clonke, grant;
  logic [14:0] addr1, addr3;
  logic [2:0]  q1, q3, p0, p1;
  logic [7:0]  x1, x3;
  logic [6:0]  y1, y3;
  logic [2:0]  c1, c3;
  logic        pl1, pl3, b1, b3, fd1, fd3;

  logic [2:0] mem [32768];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: 1-cycle and 3-cycle read latency
  always @(posedge clk) begin
    q1 <= mem[addr1];
    p0 <= mem[addr3];
    p1 <= p0;
    q3 <= p1;
  end

  frame_scanner #(.X_MAX(160), .Y_MAX(120), .RD_LAT(1)) u_lat1 (
    .CLOCK_50(clk), .resetn(resetn), .clonke(clonke), .ram_grant(grant),
    .rd_address(addr1), .rd_q(q1), .x(x1), .y(y1), .colour(c1),
    .plot(pl1), .busy(b1), .frame_done(fd1));

  frame_scanner #(.X_MAX(160), .Y_MAX(120), .RD_LAT(3)) u_lat3 (
    .CLOCK_50(clk), .resetn(resetn), .clonke(clonke), .ram_grant(grant),
    .rd_address(addr3), .rd_q(q3), .x(x3), .y(y3), .colour(c3),
    .plot(pl3), .busy(b3), .frame_done(fd3));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d, cycle %0d): got %0h expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (one per DUT) ----------------
  int  lat_of [2] = '{1, 3};
  bit  m_sa   [2];           // a frame's scan is scheduled / running
  int  m_ss   [2];           // first scan cycle
  int  m_iss  [2];           // reads issued this frame
  int  m_pld  [2];           // plots seen this frame
  int  m_fdc  [2];           // cycle of frame_done
  bit  m_pend [2];
  int  m_pt   [2][NCELL];    // cycle each cell must be plotted
  bit  mon_en = 1'b0;

  task automatic model_clear(input int d);
    m_sa[d] = 0; m_ss[d] = 0; m_iss[d] = 0; m_pld[d] = 0; m_fdc[d] = -1; m_pend[d] = 0;
  endtask

  task automatic model_start(input int d, input int s);
    m_sa[d] = 1; m_ss[d] = s; m_iss[d] = 0; m_pld[d] = 0;
  endtask

  task automatic model_step(input int d, input logic pl, input logic fd, input logic bsy,
                            input logic [7:0] ax, input logic [6:0] ay, input logic [2:0] ac,
                            input logic [14:0] aa);
    bit eb, ep;
    int ix, iy;
    logic [7:0] ex;
    logic [6:0] ey;
    eb = (m_sa[d] && cyc >= m_ss[d]) || (cyc <= m_fdc[d]);
    ep = (m_pld[d] < m_iss[d]) && (m_pt[d][m_pld[d]] == cyc);
    chk("plot", d, pl, ep);
    if (ep) begin
      ix = m_pld[d] % 160;
      iy = m_pld[d] / 160;
      ex = 8'(ix);
      ey = 7'(iy);
      chk("pixel", d, {ax, ay, ac}, {ex, ey, mem[{ex, ey}]});
      m_pld[d]++;
    end
    chk("frame_done", d, fd, (cyc == m_fdc[d]));
    chk("busy", d, bsy, eb);
    if (!eb) chk("addr_idle", d, aa, 0);
    else     chk("addr_range", d, (aa[14:7] < 8'd160) && (aa[6:0] < 7'd120), 1);
    if (!resetn) begin
      model_clear(d);
    end else begin
      if (clonke) begin
        if (eb) m_pend[d] = 1;
        else    model_start(d, cyc + 1);
      end
      if (m_sa[d] && cyc >= m_ss[d] && grant) begin
        m_pt[d][m_iss[d]] = cyc + lat_of[d] + 1;
        m_iss[d]++;
        if (m_iss[d] == NCELL) begin
          m_sa[d]  = 0;
          m_fdc[d] = cyc + lat_of[d] + 2;
        end
      end
      if (cyc == m_fdc[d] && m_pend[d]) begin
        m_pend[d] = 0;
        model_start(d, cyc + 2);
      end
    end
  endtask

  // plot accounting and first-frame timing, relative to the tick cycle c0
  int tot [2];
  int fst [2];
  int lst [2];
  int nfr [2];
  int fdt [2];
  bit sfd [2];
  bit rec_en = 1'b0;
  int c0 = 0;

  task automatic rec(input int d, input logic pl, input logic fd);
    if (pl) tot[d]++;
    if (rec_en && !sfd[d]) begin
      if (pl) begin
        if (fst[d] < 0) fst[d] = cyc - c0;
        lst[d] = cyc - c0;
        nfr[d]++;
      end
      if (fd) begin
        sfd[d] = 1;
        fdt[d] = cyc - c0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      model_step(0, pl1, fd1, b1, x1, y1, c1, addr1);
      model_step(1, pl3, fd3, b3, x3, y3, c3, addr3);
      rec(0, pl1, fd1);
      rec(1, pl3, fd3);
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_n;
    logic        tick;
    logic        gnt;
    logic        e_busy;
    logic        e_plot;
    logic        e_fd;
    logic [14:0] e_addr;
    logic        chk_xyc;
    logic [7:0]  e_x;
    logic [6:0]  e_y;
    logic [2:0]  e_c;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drop0, drop1, done;

    //               rst  clk  gnt  busy plot fd  addr     chk  x     y     c
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0,   1'b1, 8'd0, 7'd0, 3'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0,   1'b1, 8'd0, 7'd0, 3'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0,   1'b1, 8'd0, 7'd0, 3'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 15'd0,   1'b0, 8'd0, 7'd0, 3'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 15'd128, 1'b0, 8'd0, 7'd0, 3'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'd128, 1'b1, 8'd0, 7'd0, 3'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 15'd256, 1'b0, 8'd0, 7'd0, 3'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'd384, 1'b1, 8'd1, 7'd0, 3'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'd512, 1'b1, 8'd2, 7'd0, 3'd2};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0,   1'b1, 8'd0, 7'd0, 3'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0,   1'b1, 8'd0, 7'd0, 3'd0};

    for (int a = 0; a < 32768; a++) mem[a] = 3'((a >> 7) + (a & 127));
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      tot[d] = 0; fst[d] = -1; lst[d] = -1; nfr[d] = 0; fdt[d] = -1; sfd[d] = 0;
    end

    resetn = 1'b0; clonke = 1'b0; grant = 1'b1;
    repeat (3) tick();

    // idle after reset: everything stays at zero
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_lat1", 0, {x1, y1, c1, pl1, b1, fd1, addr1}, 0);
      chk("idle_lat3", 1, {x3, y3, c3, pl3, b3, fd3, addr3}, 0);
      tick();
    end

    // start latency, grant gap, first plots, reset mid-read
    for (int k = 0; k < 11; k++) begin
      resetn = tbl[k].rst_n;
      clonke = tbl[k].tick;
      grant  = tbl[k].gnt;
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", k), 0, {b1, pl1, fd1, addr1},
          {tbl[k].e_busy, tbl[k].e_plot, tbl[k].e_fd, tbl[k].e_addr});
      if (tbl[k].chk_xyc)
        chk($sformatf("vec%0d_pixel", k), 0, {x1, y1, c1}, {tbl[k].e_x, tbl[k].e_y, tbl[k].e_c});
      tick();
    end

    // full frame with grant held, plus ticks at 500 and 600 (one pending frame)
    model_clear(0); model_clear(1);
    resetn = 1'b1; clonke = 1'b0; grant = 1'b1;
    mon_en = 1'b1;
    rec_en = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 38430; i++) begin
      clonke = (i == 0 || i == 500 || i == 600);
      tick();
    end
    clonke = 1'b0;
    rec_en = 1'b0;
    chk("first_plot_lat1", 0, fst[0], 3);
    chk("last_plot_lat1", 0, lst[0], 19202);
    chk("frame_plots_lat1", 0, nfr[0], NCELL);
    chk("frame_done_lat1", 0, fdt[0], 19203);
    chk("first_plot_lat3", 1, fst[1], 5);
    chk("last_plot_lat3", 1, lst[1], 19204);
    chk("frame_plots_lat3", 1, nfr[1], NCELL);
    chk("frame_done_lat3", 1, fdt[1], 19205);
    chk("two_frames_lat1", 0, tot[0], 2 * NCELL);
    chk("two_frames_lat3", 1, tot[1], 2 * NCELL);

    // grant gaps: alternating, then random, with drops on the row/column wraps
    for (int a = 0; a < 32768; a++) mem[a] = 3'($urandom);
    tot[0] = 0; tot[1] = 0;
    drop0 = 0; drop1 = 0; done = 0;
    clonke = 1'b1;
    for (int i = 0; i < 45000; i++) begin
      if (i < 3000) grant = i[0] ? 1'b0 : 1'b1;
      else          grant = ($urandom_range(0, 3) != 0);
      if (addr1 == {8'd159, 7'd0} && b1 && !drop0) begin grant = 1'b0; drop0 = 1; end
      if (addr1 == {8'd159, 7'd119} && b1 && !drop1) begin grant = 1'b0; drop1 = 1; end
      tick();
      clonke = 1'b0;
      if (i > 5 && !b1 && !b3) begin done = 1; break; end
    end
    chk("gap_frame_end", 0, done, 1);
    chk("gap_plots_lat1", 0, tot[0], NCELL);
    chk("gap_plots_lat3", 1, tot[1], NCELL);

    // reset in the middle of a frame, at plot 7000
    grant = 1'b1;
    tot[0] = 0; tot[1] = 0;
    done = 0;
    clonke = 1'b1;
    tick();
    clonke = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      #1;
      if (tot[0] >= 7000) begin done = 1; break; end
    end
    chk("reach_plot_7000", 0, done, 1);
    resetn = 1'b0;
    model_clear(0); model_clear(1);
    tick();
    resetn = 1'b1;
    tot[0] = 0; tot[1] = 0;
    repeat (20) tick();
    chk("no_stale_lat1", 0, tot[0], 0);
    chk("no_stale_lat3", 1, tot[1], 0);

    // restart from (0,0)
    tot[0] = 0; tot[1] = 0;
    clonke = 1'b1;
    tick();
    clonke = 1'b0;
    repeat (200) tick();
    chk("restart_plots_lat1", 0, tot[0], 198);
    chk("restart_plots_lat3", 1, tot[1], 196);

    resetn = 1'b0;
    repeat (3) tick();
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_scanner.md
# frame_scanner

Downstream display stage of the game. On each game tick it sweeps the full 160x120 play grid and reads every cell's 3-bit colour from the shared grid RAM (32768x3, address = {X[7:0], Y[6:0]}). It then emits one plot per cell to the VGA adapter. The scanner shares the single-port RAM with the player/RAM update FSM: it issues reads only when granted, and in-flight reads always complete.

## Interface
Parameters:
- X_MAX, 160: grid width; X counts 0..X_MAX-1.
- Y_MAX, 120: grid height; Y counts 0..Y_MAX-1.
- RD_LAT, 1: RAM read latency in cycles, from address sampled to q valid. Must be ≥1.

Ports:
- CLOCK_50, in, 1: sole clock; all logic on posedge.
- resetn, in, 1: reset; synchronous, active-low.
- clonke, in, 1: game-tick pulse (one CLOCK_50 cycle wide); requests a frame.
- ram_grant, in, 1: scanner may issue a RAM read this cycle.
- rd_address, out, 15: RAM address {x_cnt, y_cnt}; valid whenever state is SCAN.
- rd_q, in, 3: RAM read data.
- x, out, 8: plot X coordinate (registered).
- y, out, 7: plot Y coordinate (registered).
- colour, out, 3: plot colour (registered).
- plot, out, 1: VGA write strobe; one cell per high cycle.
- busy, out, 1: high in SCAN, DRAIN and DONE.
- frame_done, out, 1: one-cycle pulse after the last plot of a frame.

## Operation
- States:
  - IDLE: wait for a start. clonke=1 or pending=1 → SCAN; clear x_cnt, y_cnt and pending.
  - SCAN: a read is issued in any cycle with ram_grant=1.
    - After each issue, advance x_cnt. At X_MAX-1, wrap x_cnt to 0 and increment y_cnt.
    - The issue of cell (X_MAX-1, Y_MAX-1) → DRAIN; counters hold.
    - With ram_grant=0: no issue, counters and rd_address hold.
  - DRAIN: wait until all in-flight reads have produced their plot → DONE.
  - DONE: assert frame_done for one cycle → IDLE.
- Read pipeline:
  - Each issued read pushes {valid=1, x_cnt, y_cnt} into an RD_LAT-deep delay line.
  - At the delay-line output, rd_q is captured with its coordinates into x/y/colour, and plot is set to 1. Otherwise plot=0.
  - An in-flight read completes regardless of ram_grant in later cycles.
- rd_address is combinational from the counters. Drive it to 0 outside SCAN.
- Pending start: clonke=1 while busy sets pending (single bit; further ticks are absorbed). The next frame starts from IDLE in the cycle after DONE. No partial frame is ever plotted.
- Counters never exceed X_MAX-1 / Y_MAX-1. Addresses with X ≥ X_MAX or Y ≥ Y_MAX are never issued.
- Reset, including mid-frame: on resetn=0 at a clock edge:
  - state = IDLE; counters and pending cleared; delay line invalidated.
  - x=0, y=0, colour=0, plot=0, busy=0, frame_done=0, rd_address=0.
  - No plot is emitted for reads issued before reset.

## Timing
- Issue in cycle t (SCAN with ram_grant=1) → rd_q valid in cycle t+RD_LAT → plot=1 with that cell in cycle t+RD_LAT+1.
- Start latency: clonke high in cycle 0 (IDLE) → SCAN in cycle 1 → first issue in cycle 1 if granted.
- With ram_grant held at 1 and RD_LAT=1:
  - issues in cycles 1..19200;
  - plots in cycles 3..19202, exactly 19200 consecutive plot cycles;
  - frame_done=1 in cycle 19203;
  - IDLE in cycle 19204.
- Each ram_grant=0 cycle during SCAN delays every later issue and plot by one cycle. It creates a one-cycle gap in plot RD_LAT+1 cycles later.
- Plot order is raster: X fastest, then Y.

## Structure
- Shared package game_pkg holds:
  - X_MAX/Y_MAX defaults and ADDR_W=15 (X_W=8, Y_W=7);
  - the coordinate-to-address packing {X, Y}, identical to the player-location field packing;
  - the colour constants (3'b000 empty/background);
  - the frame_scanner state encoding.
- One sub-module: scan_delay, a parameterised RD_LAT-stage shift register of {valid, x, y} with synchronous active-low clear.

## Test plan
- Reset, then idle: all outputs 0 and busy=0 for 100 cycles with no clonke.
- Full frame, RAM preloaded with colour = (X+Y)%8, grant held at 1:
  - exactly 19200 plots in raster order, each with colour matching its cell;
  - first plot (0,0) in cycle 3 after clonke, last (159,119) in cycle 19202;
  - frame_done in cycle 19203.
- Grant gaps: ram_grant toggling 1,0 every cycle → still 19200 plots with correct colours, and no address skipped or repeated. Also drop grant exactly on the issue of (159,0) and (159,119); row and column wrap must stay correct.
- Tick while busy: clonke at cycles 0, 500 and 600 → one pending start. Second frame begins in the cycle after the first frame_done; exactly 2×19200 plots in total.
- Reset mid-frame: resetn low at plot 7000 → plot=0 from the next cycle and no stale plot after release. A new clonke restarts the frame at (0,0).
- RD_LAT=3 build: plot of the cell issued in cycle t appears in cycle t+4. frame_done follows the last plot by one cycle.
